// File: rtl/mem_pkg.sv
// Shared types for the RAM request master: FSM state encoding, default
// widths and the default-width command record.
package mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Master FSM states, exposed on the debug port with this encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // One load/store command as seen on the core port (default widths).
    typedef struct packed {
        logic              write;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_cmd_skid.sv
// One-entry command buffer between the core port and the request FSM.
// Valid/ready: a transfer happens on a posedge where valid and ready are both 1;
// in_ready_o is simply "entry empty" and out_valid_o is "entry full", so a push
// and a pop can never land on the same edge.
module mem_cmd_skid
    import mem_pkg::*;
#(
    parameter int W = 1 + AW_DEF + DW_DEF
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_pop_i
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign in_ready_o  = !full_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    // Next-state: fill when empty and offered, drain when full and popped.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (out_pop_i && full_q) begin
            full_d = 1'b0;
        end
    end

    // Entry register; reset empties the buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/mem_request_master.sv
// CPU-side initiator for the single-word RAM request/ack protocol.
// Core port valid/ready: a command transfers on a posedge where cmd_valid and
// cmd_ready are both 1; cmd_ready only drops while the one-entry buffer is full.
// Each command becomes a single one-cycle readReq/writeReq pulse, then the FSM
// waits for the matching ack or a timeout and reports on the response port.
// TIMEOUT must be at least 3 so a normal ack (third cycle after issue) is never
// preempted by the timeout.
module mem_request_master
    import mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_error,
    output logic [AW-1:0] ramAddress,
    output logic [DW-1:0] ramOut,
    output logic          readReq,
    output logic          writeReq,
    input  logic [DW-1:0] ramValue,
    input  logic          readAck,
    input  logic          writeAck,
    output logic [1:0]    dbg_state
);

    localparam int CW    = $clog2(TIMEOUT) + 1;
    localparam int CMD_W = 1 + AW + DW;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_cmd_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            read_req_q, read_req_d;
    logic            write_req_q, write_req_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_error_q, rsp_error_d;
    logic            rsp_write_q, rsp_write_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            kind_q, kind_d;

    req_cmd_t        port_cmd;
    req_cmd_t        skid_cmd;
    req_cmd_t        next_cmd;
    logic [CMD_W-1:0] skid_data;
    logic            skid_full;
    logic            skid_in_ready;
    logic            skid_push;
    logic            skid_pop;
    logic            issue;
    logic            ack_any;
    logic            ack_ok;

    assign port_cmd  = {cmd_write, cmd_addr, cmd_wdata};
    assign skid_cmd  = skid_data;
    // In IDLE with an empty buffer the port command goes straight to ISSUE;
    // in every other state an accepted command parks in the buffer.
    assign skid_push = cmd_valid && (state_q != ST_IDLE);
    assign cmd_ready = skid_in_ready;

    mem_cmd_skid #(.W(CMD_W)) u_skid (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (skid_push),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (port_cmd),
        .out_valid_o (skid_full),
        .out_data_o  (skid_data),
        .out_pop_i   (skid_pop)
    );

    assign readReq    = read_req_q;
    assign writeReq   = write_req_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_error  = rsp_error_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign ramAddress = addr_q;
    assign ramOut     = wdata_q;
    assign dbg_state  = state_q;

    // Next-state and registered-output logic for the request FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_req_d  = 1'b0;
        write_req_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        kind_d      = kind_q;
        skid_pop    = 1'b0;
        issue       = 1'b0;
        // The buffered command is always older than the one on the port.
        next_cmd    = skid_full ? skid_cmd : port_cmd;
        ack_any     = readAck || writeAck;
        // Both acks at once never counts as the expected one.
        ack_ok      = kind_q ? (writeAck && !readAck) : (readAck && !writeAck);

        case (state_q)
            ST_IDLE: begin
                if (skid_full || cmd_valid) begin
                    issue = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = cnt_q + CW'(1);
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (ack_any) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = kind_q;
                    rsp_error_d = !ack_ok;
                    if (ack_ok && !kind_q) begin
                        rsp_rdata_d = ramValue;
                    end
                    if (skid_full) begin
                        issue = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = kind_q;
                    rsp_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering ISSUE: latch the command and raise exactly one request pulse.
        // The counter starts here so a timeout lands TIMEOUT cycles after the pulse.
        if (issue) begin
            skid_pop    = skid_full;
            state_d     = ST_ISSUE;
            cnt_d       = '0;
            addr_d      = next_cmd.addr;
            wdata_d     = next_cmd.wdata;
            kind_d      = next_cmd.write;
            read_req_d  = !next_cmd.write;
            write_req_d = next_cmd.write;
        end
    end

    // State, counter and output registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_req_q  <= 1'b0;
            write_req_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            kind_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_req_q  <= read_req_d;
            write_req_q <= write_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            kind_q      <= kind_d;
        end
    end

endmodule

// File: tb/tb_mem_request_master.sv
// Directed bench for mem_request_master with a four-mode RAM responder
// (0 normal, 1 never acks, 2 wrong-kind ack, 3 both acks) over a 256-byte RAM.
module tb_mem_request_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramValue = '0;
  logic        readAck = 1'b0;
  logic        writeAck = 1'b0;
  logic [1:0]  dbg_state;

  mem_request_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .ramAddress (ramAddress),
    .ramOut     (ramOut),
    .readReq    (readReq),
    .writeReq   (writeReq),
    .ramValue   (ramValue),
    .readAck    (readAck),
    .writeAck   (writeAck),
    .dbg_state  (dbg_state)
  );

  // ---------------- responder model ----------------
  logic [7:0]  ram [0:255];
  int          resp_mode = 0;
  logic        pend = 1'b0;
  logic        pkind = 1'b0;
  logic [7:0]  pa = '0;
  logic [31:0] pd = '0;

  always @(posedge clk) begin
    readAck  <= 1'b0;
    writeAck <= 1'b0;
    if (pend) begin
      pend <= 1'b0;
      case (resp_mode)
        0: begin
          if (pkind) begin
            ram[pa]        = pd[7:0];
            ram[pa + 8'd1] = pd[15:8];
            ram[pa + 8'd2] = pd[23:16];
            ram[pa + 8'd3] = pd[31:24];
            writeAck <= 1'b1;
          end else begin
            ramValue <= {ram[pa + 8'd3], ram[pa + 8'd2], ram[pa + 8'd1], ram[pa]};
            readAck  <= 1'b1;
          end
        end
        2: begin
          if (pkind) readAck <= 1'b1;
          else       writeAck <= 1'b1;
        end
        3: begin
          readAck  <= 1'b1;
          writeAck <= 1'b1;
        end
        default: ;
      endcase
    end else if (readReq || writeReq) begin
      pend  <= 1'b1;
      pkind <= writeReq;
      pa    <= ramAddress[7:0];
      pd    <= ramOut;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int held_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  always @(negedge clk) begin
    if (readReq) rd_cnt++;
    if (writeReq) wr_cnt++;
    if (readReq && writeReq) both_cnt++;
    if ((readReq && prev_rd) || (writeReq && prev_wr)) held_cnt++;
    prev_rd = readReq;
    prev_wr = writeReq;
    if (rsp_valid) got_q.push_back({rsp_error, rsp_write, rsp_rdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int waits);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("send_ready_bound", 64'(waits < 50), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts negedges until rsp_valid is seen, bounded.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n;
    int rd0;
    int wr0;
    logic [33:0] g;
    logic [33:0] e;

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22; ram[8'h12] = 8'h33; ram[8'h13] = 8'h44;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readReq", 64'(readReq), 64'd0);
    chk("rst_writeReq", 64'(writeReq), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_rsp_write", 64'(rsp_write), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_ramAddress", 64'(ramAddress), 64'd0);
    chk("rst_ramOut", 64'(ramOut), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: single load from 0x10
    rd0 = rd_cnt;
    send(1'b0, 32'h10, 32'h0, w);
    chk("t1_req_high", 64'(readReq), 64'd1);
    chk("t1_addr", 64'(ramAddress), 64'h10);
    @(negedge clk);
    chk("t1_req_pulse", 64'(readReq), 64'd0);
    @(negedge clk);
    chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rdata", 64'(rsp_rdata), 64'h44332211);
    chk("t1_error", 64'(rsp_error), 64'd0);
    chk("t1_write", 64'(rsp_write), 64'd0);
    @(negedge clk);
    chk("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("t1_req_count", 64'(rd_cnt - rd0), 64'd1);

    // 2: store 0xDEADBEEF @0x20 then load 0x20 back-to-back
    send(1'b1, 32'h20, 32'hDEADBEEF, w);
    chk("t2_wreq", 64'(writeReq), 64'd1);
    chk("t2_wdata", 64'(ramOut), 64'hDEADBEEF);
    send(1'b0, 32'h20, 32'h0, w);
    chk("t2_load_wait", 64'(w), 64'd0);
    chk("t2_skid_full", 64'(cmd_ready), 64'd0);
    chk("t2_no_req", 64'({readReq, writeReq}), 64'd0);
    @(negedge clk);
    chk("t2_rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("t2_w_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_w_rsp_write", 64'(rsp_write), 64'd1);
    chk("t2_w_rsp_error", 64'(rsp_error), 64'd0);
    chk("t2_w_rdata_held", 64'(rsp_rdata), 64'h44332211);
    chk("t2_rreq", 64'(readReq), 64'd1);
    chk("t2_ready_again", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("t2_r_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_r_rsp_write", 64'(rsp_write), 64'd0);
    chk("t2_r_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("t2_ram_lo", 64'(ram[8'h20]), 64'hEF);
    chk("t2_ram_hi", 64'(ram[8'h23]), 64'hDE);
    @(negedge clk);
    got_q.delete();

    // 3: three consecutive commands, strict order
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    exp_q.push_back({1'b0, 1'b0, 32'h44332211});
    exp_q.push_back({1'b0, 1'b1, 32'h44332211});
    exp_q.push_back({1'b0, 1'b0, 32'h01020304});
    send(1'b0, 32'h10, 32'h0, w);
    send(1'b1, 32'h30, 32'h01020304, w);
    chk("t3_b_wait", 64'(w), 64'd0);
    send(1'b0, 32'h30, 32'h0, w);
    chk("t3_c_wait", 64'(w), 64'd2);
    n = 0;
    while (got_q.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("t3_rsp_count", 64'(got_q.size()), 64'd3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (got_q.size() != 0) g = got_q.pop_front();
      else g = 'x;
      chk("t3_rsp", 64'(g), 64'(e));
    end
    chk("t3_req_total", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd3);

    // 4: no ack, timeout 8 cycles after the request pulse
    resp_mode = 1;
    send(1'b0, 32'h40, 32'h0, w);
    wait_rsp(n);
    chk("t4_timeout_cycles", 64'(n), 64'd8);
    chk("t4_error", 64'(rsp_error), 64'd1);
    chk("t4_rdata_kept", 64'(rsp_rdata), 64'h01020304);
    chk("t4_state_idle", 64'(dbg_state), 64'd0);
    @(negedge clk);
    chk("t4_rsp_pulse", 64'(rsp_valid), 64'd0);

    // 5: wrong-kind ack, then both acks
    resp_mode = 2;
    send(1'b0, 32'h10, 32'h0, w);
    wait_rsp(n);
    chk("t5_latency", 64'(n), 64'd3);
    chk("t5_error", 64'(rsp_error), 64'd1);
    chk("t5_rdata_kept", 64'(rsp_rdata), 64'h01020304);
    @(negedge clk);
    resp_mode = 3;
    send(1'b1, 32'h50, 32'h55, w);
    wait_rsp(n);
    chk("t5b_latency", 64'(n), 64'd3);
    chk("t5b_error", 64'(rsp_error), 64'd1);
    chk("t5b_write", 64'(rsp_write), 64'd1);
    @(negedge clk);

    // 6: reset during WAIT with the buffer full
    resp_mode = 1;
    got_q.delete();
    send(1'b0, 32'h10, 32'h0, w);
    send(1'b0, 32'h14, 32'h0, w);
    chk("t6_skid_full", 64'(cmd_ready), 64'd0);
    chk("t6_in_wait", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_req_low", 64'({readReq, writeReq}), 64'd0);
    chk("t6_rsp_low", 64'(rsp_valid), 64'd0);
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    chk("t6_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    repeat (12) @(negedge clk);
    chk("t6_no_rsp", 64'(got_q.size()), 64'd0);
    chk("t6_no_req", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd0);
    resp_mode = 0;
    send(1'b0, 32'h10, 32'h0, w);
    wait_rsp(n);
    chk("t6_load_latency", 64'(n), 64'd3);
    chk("t6_load_rdata", 64'(rsp_rdata), 64'h44332211);
    chk("t6_load_error", 64'(rsp_error), 64'd0);
    @(negedge clk);

    // Protocol invariants over the whole run
    chk("never_both_req", 64'(both_cnt), 64'd0);
    chk("req_never_held", 64'(held_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
